// File: rtl/comparator_rr_sched.sv
// Round-robin arbiter in front of one shared unsigned magnitude comparator.
// Grants one requester, captures its operands, returns a registered result.
module comparator_rr_sched #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 4,
  localparam int IDW  = $clog2(NREQ)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NREQ-1:0]        req,
  input  logic [NREQ*WIDTH-1:0]  data1_bus,
  input  logic [NREQ*WIDTH-1:0]  data2_bus,
  output logic [NREQ-1:0]        gnt,
  output logic                   busy,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [IDW-1:0]         rsp_id,
  output logic                   rsp_great,
  output logic                   rsp_equal,
  output logic                   rsp_less
);

  typedef enum logic [1:0] {IDLE, CMP, RESP} state_t;

  state_t           state, state_next;
  logic [IDW-1:0]   ptr, winner, cur_id;
  logic             found;
  logic [WIDTH-1:0] op_a, op_b, sel_a, sel_b;

  // Scan ptr+1, ptr+2, ... modulo NREQ; the first asserted request wins.
  always_comb begin
    int unsigned idx;
    found  = 1'b0;
    winner = '0;
    idx    = 0;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      idx = (32'(ptr) + k) % unsigned'(NREQ);
      if (!found && req[idx[IDW-1:0]]) begin
        found  = 1'b1;
        winner = idx[IDW-1:0];
      end
    end
  end

  always_comb begin
    sel_a = '0;
    sel_b = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (winner == i[IDW-1:0]) begin
        sel_a = data1_bus[i*WIDTH +: WIDTH];
        sel_b = data2_bus[i*WIDTH +: WIDTH];
      end
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (found) state_next = CMP;
      CMP:     state_next = RESP;
      RESP:    if (rsp_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      ptr       <= IDW'(NREQ - 1);
      cur_id    <= '0;
      op_a      <= '0;
      op_b      <= '0;
      gnt       <= '0;
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_great <= 1'b0;
      rsp_equal <= 1'b0;
      rsp_less  <= 1'b0;
    end else begin
      state <= state_next;
      gnt   <= '0;
      case (state)
        IDLE: begin
          if (found) begin
            gnt    <= NREQ'(1) << winner;
            op_a   <= sel_a;
            op_b   <= sel_b;
            cur_id <= winner;
            ptr    <= winner;
          end
        end
        CMP: begin
          rsp_valid <= 1'b1;
          rsp_id    <= cur_id;
          rsp_great <= (op_a > op_b);
          rsp_equal <= (op_a == op_b);
          rsp_less  <= (op_a < op_b);
        end
        RESP: begin
          if (rsp_ready) rsp_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_comparator_rr_sched.sv
// Bench for comparator_rr_sched: transaction-level reference model checked
// every cycle, directed scenarios with literal expectations, random traffic.
module tb_comparator_rr_sched;
  localparam int NREQ  = 4;
  localparam int WIDTH = 4;
  localparam int IDW   = 2;

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic [NREQ-1:0]       req;
  logic [NREQ*WIDTH-1:0] data1_bus, data2_bus;
  logic [NREQ-1:0]       gnt;
  logic                  busy, rsp_valid, rsp_ready;
  logic [IDW-1:0]        rsp_id;
  logic                  rsp_great, rsp_equal, rsp_less;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  comparator_rr_sched #(.NREQ(NREQ), .WIDTH(WIDTH)) dut (
    .clk(clk), .rst_n(rst_n), .req(req),
    .data1_bus(data1_bus), .data2_bus(data2_bus),
    .gnt(gnt), .busy(busy), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_great(rsp_great), .rsp_equal(rsp_equal), .rsp_less(rsp_less)
  );

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic int pick(input logic [NREQ-1:0] r, input int p);
    int w = -1;
    for (int k = 1; k <= NREQ; k++)
      if (w < 0 && r[(p + k) % NREQ]) w = (p + k) % NREQ;
    return w;
  endfunction

  function automatic int slice_of(input logic [NREQ*WIDTH-1:0] bus, input int i);
    logic [NREQ*WIDTH-1:0] t = bus >> (i * WIDTH);
    return int'(t[WIDTH-1:0]);
  endfunction

  bit m_active = 1'b0;   // a transaction is in flight
  bit m_answer = 1'b0;   // in flight and its result is being offered
  int m_ptr    = NREQ - 1;
  int m_id     = 0;
  int m_a      = 0;
  int m_b      = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_active <= 1'b0;
      m_answer <= 1'b0;
      m_ptr    <= NREQ - 1;
    end else if (!m_active) begin
      if (req != '0) begin
        m_active <= 1'b1;
        m_answer <= 1'b0;
        m_id     <= pick(req, m_ptr);
        m_ptr    <= pick(req, m_ptr);
        m_a      <= slice_of(data1_bus, pick(req, m_ptr));
        m_b      <= slice_of(data2_bus, pick(req, m_ptr));
      end
    end else if (!m_answer) begin
      m_answer <= 1'b1;
    end else if (rsp_ready) begin
      m_active <= 1'b0;
      m_answer <= 1'b0;
    end
  end

  always @(negedge clk) begin
    chk("gnt", int'(gnt), (m_active && !m_answer) ? (1 << m_id) : 0);
    chk("busy", int'(busy), int'(m_active));
    chk("rsp_valid", int'(rsp_valid), int'(m_answer));
    if (m_answer) begin
      chk("rsp_id", int'(rsp_id), m_id);
      chk("rsp_great", int'(rsp_great), (m_a > m_b) ? 1 : 0);
      chk("rsp_equal", int'(rsp_equal), (m_a == m_b) ? 1 : 0);
      chk("rsp_less", int'(rsp_less), (m_a < m_b) ? 1 : 0);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic set_ops(input int i, input int a, input int b);
    data1_bus[i*WIDTH +: WIDTH] = WIDTH'(a);
    data2_bus[i*WIDTH +: WIDTH] = WIDTH'(b);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_gnt"}, int'(gnt), 0);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_valid"}, int'(rsp_valid), 0);
    chk({tag, "_id"}, int'(rsp_id), 0);
    chk({tag, "_flags"}, int'({rsp_great, rsp_equal, rsp_less}), 0);
  endtask

  task automatic do_reset();
    req   = '0;
    rst_n = 1'b0;
    #1;
    chk_all_zero("reset");
    step();
    step();
    rst_n = 1'b1;
  endtask

  // Waits (bounded) for a grant, then checks grant, response and release.
  task automatic expect_op(input int idx, input int g, input int e, input int l, input bit drop);
    int waited = 0;
    while (gnt == '0 && waited < 20) begin
      step();
      waited++;
    end
    chk("gnt_seen", int'(gnt != '0), 1);
    chk("gnt_onehot", int'(gnt), 1 << idx);
    chk("busy_gnt", int'(busy), 1);
    if (drop) req[idx] = 1'b0;
    step();
    chk("op_valid", int'(rsp_valid), 1);
    chk("op_id", int'(rsp_id), idx);
    chk("op_flags", int'({rsp_great, rsp_equal, rsp_less}), (g << 2) | (e << 1) | l);
    step();
    chk("op_valid_clear", int'(rsp_valid), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int gcyc[$];
    rst_n = 1'b1; req = '0; data1_bus = '0; data2_bus = '0; rsp_ready = 1'b1;
    #1;
    do_reset();

    // single requester 1: 10 < 12
    set_ops(1, 10, 12);
    req = 4'b0010;
    expect_op(1, 0, 0, 1, 1'b1);

    // all requesting from reset: order 0,1,2,3
    do_reset();
    set_ops(0, 15, 15); set_ops(1, 15, 12); set_ops(2, 3, 9); set_ops(3, 0, 0);
    req = 4'b1111;
    expect_op(0, 0, 1, 0, 1'b1);
    expect_op(1, 1, 0, 0, 1'b1);
    expect_op(2, 0, 0, 1, 1'b1);
    expect_op(3, 0, 1, 0, 1'b1);

    // persistent requester 0: a grant every 3 cycles
    do_reset();
    set_ops(0, 15, 0);
    req = 4'b0001;
    for (int c = 0; c < 15; c++) begin
      step();
      if (gnt == 4'b0001) gcyc.push_back(c);
      if (rsp_valid) chk("persist_great", int'(rsp_great), 1);
    end
    chk("persist_count", gcyc.size(), 5);
    if (gcyc.size() > 0) chk("persist_first", gcyc[0], 0);
    for (int i = 1; i < gcyc.size(); i++) chk("persist_spacing", gcyc[i] - gcyc[i-1], 3);
    req = '0;
    step(); step(); step();

    // response held under back-pressure
    do_reset();
    set_ops(1, 5, 3);
    req = 4'b0010;
    rsp_ready = 1'b0;
    step();
    chk("bp_gnt", int'(gnt), 2);
    req = '0;
    step();
    chk("bp_valid0", int'(rsp_valid), 1);
    for (int c = 0; c < 5; c++) begin
      data1_bus = 16'($urandom);
      req = 4'b1101;
      step();
      chk("bp_valid", int'(rsp_valid), 1);
      chk("bp_id", int'(rsp_id), 1);
      chk("bp_flags", int'({rsp_great, rsp_equal, rsp_less}), 4);
      chk("bp_nognt", int'(gnt), 0);
      chk("bp_busy", int'(busy), 1);
    end
    set_ops(0, 7, 7); set_ops(2, 1, 14); set_ops(3, 2, 2);
    rsp_ready = 1'b1;
    step();
    chk("bp_release_valid", int'(rsp_valid), 0);
    chk("bp_release_busy", int'(busy), 0);
    step();
    chk("bp_next_gnt", int'(gnt), 4);

    // after a grant to 2, requests 0 and 2 -> wrap to 0, then 2
    req = 4'b0101;
    step();
    chk("wrap_valid", int'(rsp_valid), 1);
    chk("wrap_id", int'(rsp_id), 2);
    chk("wrap_less", int'(rsp_less), 1);
    step();
    expect_op(0, 0, 1, 0, 1'b1);
    expect_op(2, 0, 0, 1, 1'b1);

    // reset during CMP aborts the operation
    do_reset();
    set_ops(0, 9, 9);
    req = 4'b0001;
    step();
    chk("abort_gnt", int'(gnt), 1);
    req = '0;
    rst_n = 1'b0;
    #1;
    chk_all_zero("abort");
    step();
    step();
    chk("abort_novalid", int'(rsp_valid), 0);
    req = 4'b1100;
    rst_n = 1'b1;
    step();
    chk("abort_regrant", int'(gnt), 4);
    req = '0;
    step(); step();

    // random traffic
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      step();
      if (c == 1500) begin
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
      end
      for (int i = 0; i < NREQ; i++) begin
        if (req[i] && gnt[i]) begin
          if ($urandom % 4 == 0) begin
            int a = int'($urandom_range(0, 15));
            set_ops(i, a, ($urandom % 4 == 0) ? a : int'($urandom_range(0, 15)));
          end else begin
            req[i] = 1'b0;
          end
        end else if (!req[i] && ($urandom % 3 == 0)) begin
          int a = int'($urandom_range(0, 15));
          set_ops(i, a, ($urandom % 4 == 0) ? a : int'($urandom_range(0, 15)));
          req[i] = 1'b1;
        end
      end
      rsp_ready = ($urandom % 2 == 0);
    end

    step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
